// File: rtl/ram_stream_reader_if.sv
// Bus bundle between the burst reader, its RAM read port and the stream consumer.
// The slave modport is the reader's view; the master modport is the environment's view.
interface ram_stream_reader_if #(
    parameter int ADDRESS_WIDTH = 4,
    parameter int DATA_WIDTH    = 8
);
    logic                     Start_i;
    logic [ADDRESS_WIDTH-1:0] BaseAddress_i;
    logic [ADDRESS_WIDTH:0]   Length_i;
    logic                     Busy_o;
    logic                     Done_o;
    logic                     RamReadEnable_o;
    logic [ADDRESS_WIDTH-1:0] RamAddress_o;
    logic [DATA_WIDTH-1:0]    RamData_i;
    logic [DATA_WIDTH-1:0]    StreamData_o;
    logic                     StreamValid_o;
    logic                     StreamReady_i;

    modport slave (
        input  Start_i, BaseAddress_i, Length_i, RamData_i, StreamReady_i,
        output Busy_o, Done_o, RamReadEnable_o, RamAddress_o, StreamData_o, StreamValid_o
    );

    modport master (
        output Start_i, BaseAddress_i, Length_i, RamData_i, StreamReady_i,
        input  Busy_o, Done_o, RamReadEnable_o, RamAddress_o, StreamData_o, StreamValid_o
    );
endinterface

// File: rtl/ram_stream_reader.sv
// Burst read initiator: issues RAM reads under a 4-word credit limit and streams the
// returned words through a 4-entry first-word-fall-through FIFO.
module ram_stream_reader #(
    parameter int ADDRESS_WIDTH = 4,
    parameter int DATA_WIDTH    = 8
) (
    input  logic                Clock,
    input  logic                Reset,
    ram_stream_reader_if.slave  bus
);
    typedef enum logic [1:0] {S_IDLE, S_READ, S_DRAIN, S_DONE} state_t;

    state_t                   r_state, w_state_nxt;
    logic [ADDRESS_WIDTH-1:0] r_addr, w_addr_nxt;
    logic [ADDRESS_WIDTH:0]   r_remaining, w_remaining_nxt;
    logic [ADDRESS_WIDTH-1:0] r_ram_addr, w_ram_addr_nxt;
    logic                     r_ren;
    logic                     r_rd_ret;
    logic [2:0]               r_outst;
    logic [2:0]               r_count;
    logic [1:0]               r_wptr, r_rptr;
    logic [DATA_WIDTH-1:0]    r_mem [4];
    logic                     w_issue, w_pop, w_push;

    assign w_pop  = (r_count != 3'd0) && bus.StreamReady_i;
    assign w_push = r_rd_ret;

    // Issue decision: outstanding counts in-flight reads plus FIFO occupancy, so a pop
    // in this cycle frees a credit for a read issued in the same cycle.
    always_comb begin
        w_state_nxt     = r_state;
        w_addr_nxt      = r_addr;
        w_remaining_nxt = r_remaining;
        w_ram_addr_nxt  = r_ram_addr;
        w_issue         = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.Start_i) begin
                    if (bus.Length_i == '0) begin
                        w_state_nxt = S_DONE;
                    end else begin
                        w_issue         = 1'b1;
                        w_ram_addr_nxt  = bus.BaseAddress_i;
                        w_addr_nxt      = bus.BaseAddress_i + 1'b1;
                        w_remaining_nxt = bus.Length_i - 1'b1;
                        w_state_nxt     = (bus.Length_i == 1) ? S_DRAIN : S_READ;
                    end
                end
            end
            S_READ: begin
                if ((r_remaining != '0) && ((r_outst < 3'd4) || w_pop)) begin
                    w_issue         = 1'b1;
                    w_ram_addr_nxt  = r_addr;
                    w_addr_nxt      = r_addr + 1'b1;
                    w_remaining_nxt = r_remaining - 1'b1;
                    if (r_remaining == 1) w_state_nxt = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (r_outst == {2'b00, w_pop}) w_state_nxt = S_DONE;
            end
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            r_state     <= S_IDLE;
            r_addr      <= '0;
            r_remaining <= '0;
            r_ram_addr  <= '0;
            r_ren       <= 1'b0;
            r_rd_ret    <= 1'b0;
            r_outst     <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_addr      <= w_addr_nxt;
            r_remaining <= w_remaining_nxt;
            r_ram_addr  <= w_ram_addr_nxt;
            r_ren       <= w_issue;
            r_rd_ret    <= r_ren;
            case ({w_issue, w_pop})
                2'b10:   r_outst <= r_outst + 3'd1;
                2'b01:   r_outst <= r_outst - 3'd1;
                default: r_outst <= r_outst;
            endcase
        end
    end

    // FIFO control; storage itself is left unreset and masked at the output instead.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + 2'd1;
            if (w_pop)  r_rptr <= r_rptr + 2'd1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 3'd1;
                2'b01:   r_count <= r_count - 3'd1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge Clock) begin
        if (w_push) r_mem[r_wptr] <= bus.RamData_i;
    end

    assign bus.StreamValid_o   = (r_count != 3'd0);
    assign bus.StreamData_o    = (r_count != 3'd0) ? r_mem[r_rptr] : '0;
    assign bus.RamReadEnable_o = r_ren;
    assign bus.RamAddress_o    = r_ram_addr;
    assign bus.Busy_o          = (r_state == S_READ) || (r_state == S_DRAIN);
    assign bus.Done_o          = (r_state == S_DONE);
endmodule

// File: tb/tb_ram_stream_reader.sv
// Directed bench for ram_stream_reader: table of bursts against a RAM preloaded with
// Mem[i] = i ^ 8'hA5, plus a hand-written reset-mid-burst sequence.
module tb_ram_stream_reader;
    logic Clock = 1'b0;
    logic Reset = 1'b1;
    always #5 Clock = ~Clock;

    ram_stream_reader_if #(.ADDRESS_WIDTH(4), .DATA_WIDTH(8)) bus ();

    ram_stream_reader #(.ADDRESS_WIDTH(4), .DATA_WIDTH(8)) dut (
        .Clock (Clock),
        .Reset (Reset),
        .bus   (bus.slave)
    );

    // RAM model: samples enable/address at an edge, data valid after that edge.
    logic [7:0] ram_mem [16];
    logic [7:0] ram_q = 8'h00;
    always @(posedge Clock) if (bus.RamReadEnable_o) ram_q <= ram_mem[bus.RamAddress_o];
    assign bus.RamData_i = ram_q;

    int n_cmp = 0;
    int n_bad = 0;
    int n_ovf = 0;

    always @(negedge Clock) if (!Reset && dut.r_rd_ret && dut.r_count == 3'd4) n_ovf++;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [3:0]      base;
        logic [4:0]      len;
        int              hold;
        int              restart;
        logic [3:0][7:0] exp;
    } vec_t;

    function automatic vec_t mk(input logic [3:0] b, input logic [4:0] l, input int h, input int r,
                                input logic [7:0] e0, e1, e2, e3);
        vec_t v;
        v.base = b; v.len = l; v.hold = h; v.restart = r;
        v.exp = {e3, e2, e1, e0};
        return v;
    endfunction

    logic [3:0] addr_q [$];
    logic [7:0] data_q [$];

    task automatic run_vec(input vec_t v);
        int cyc, first_re, first_valid, last_xfer, done_cyc, done_cnt, busy_cnt;
        int overlap, hold_reads, stable_viol;
        bit prev_stall;
        logic [7:0] prev_data, expw;
        addr_q.delete(); data_q.delete();
        first_re = -1; first_valid = -1; last_xfer = -1; done_cyc = -1;
        done_cnt = 0; busy_cnt = 0; overlap = 0; hold_reads = 0; stable_viol = 0;
        prev_stall = 1'b0; prev_data = 8'h00;
        @(negedge Clock);
        bus.Start_i = 1'b1; bus.BaseAddress_i = v.base; bus.Length_i = v.len;
        bus.StreamReady_i = (v.hold == 0);
        cyc = 0;
        @(negedge Clock);
        while (!((done_cyc >= 0 && cyc > done_cyc + 2) || cyc >= 400)) begin
            bus.Start_i = (cyc == v.restart);
            bus.BaseAddress_i = (cyc == v.restart) ? 4'd8 : 4'd0;
            bus.Length_i = (cyc == v.restart) ? 5'd3 : 5'd0;
            bus.StreamReady_i = (cyc >= v.hold);
            if (bus.RamReadEnable_o) begin
                addr_q.push_back(bus.RamAddress_o);
                if (first_re < 0) first_re = cyc;
                if (cyc < v.hold) hold_reads++;
            end
            if (bus.StreamValid_o && first_valid < 0) first_valid = cyc;
            if (bus.StreamValid_o && bus.StreamReady_i) begin
                data_q.push_back(bus.StreamData_o);
                last_xfer = cyc;
            end
            if (bus.StreamValid_o && !bus.StreamReady_i) begin
                if (prev_stall && bus.StreamData_o !== prev_data) stable_viol++;
                prev_stall = 1'b1;
                prev_data = bus.StreamData_o;
            end else begin
                prev_stall = 1'b0;
            end
            if (bus.Busy_o) busy_cnt++;
            if (bus.Done_o) begin
                done_cnt++;
                if (done_cyc < 0) done_cyc = cyc;
                if (bus.Busy_o) overlap++;
            end
            @(negedge Clock);
            cyc++;
        end
        bus.Start_i = 1'b0;
        chk("done_seen", {31'd0, done_cyc >= 0}, 32'd1);
        chk("done_pulses", done_cnt, 1);
        chk("busy_during_done", overlap, 0);
        chk("n_reads", addr_q.size(), v.len);
        chk("n_words", data_q.size(), v.len);
        for (int k = 0; k < addr_q.size(); k++)
            chk($sformatf("addr[%0d]", k), addr_q[k], 4'(v.base + k));
        for (int k = 0; k < data_q.size(); k++) begin
            expw = (k < 4) ? v.exp[k] : ({4'h0, 4'(v.base + k)} ^ 8'hA5);
            chk($sformatf("word[%0d]", k), data_q[k], expw);
        end
        if (v.len == 0) begin
            chk("len0_done_cycle", done_cyc, 0);
            chk("len0_busy", busy_cnt, 0);
        end else begin
            chk("first_valid_latency", first_valid - first_re, 2);
            chk("done_after_last", done_cyc - last_xfer, 1);
        end
        if (v.hold > 0) begin
            chk("reads_under_backpressure", hold_reads, 4);
            chk("stall_data_stable", stable_viol, 0);
        end
    endtask

    vec_t vecs [7];
    vec_t post;

    initial begin
        int xfers;
        int cnt;
        for (int i = 0; i < 16; i++) ram_mem[i] = 8'(i) ^ 8'hA5;
        bus.Start_i = 1'b0; bus.BaseAddress_i = '0; bus.Length_i = '0; bus.StreamReady_i = 1'b0;

        vecs[0] = mk(4'd0,  5'd4,  0,  -1, 8'hA5, 8'hA4, 8'hA7, 8'hA6);
        vecs[1] = mk(4'd14, 5'd4,  0,  -1, 8'hAB, 8'hAA, 8'hA5, 8'hA4);
        vecs[2] = mk(4'd0,  5'd16, 10, -1, 8'hA5, 8'hA4, 8'hA7, 8'hA6);
        vecs[3] = mk(4'd0,  5'd0,  0,  -1, 8'h00, 8'h00, 8'h00, 8'h00);
        vecs[4] = mk(4'd2,  5'd6,  0,   2, 8'hA7, 8'hA6, 8'hA1, 8'hA0);
        vecs[5] = mk(4'd5,  5'd1,  0,  -1, 8'hA0, 8'h00, 8'h00, 8'h00);
        vecs[6] = mk(4'd9,  5'd16, 0,  -1, 8'hAC, 8'hAF, 8'hAE, 8'hA9);
        post    = mk(4'd3,  5'd2,  0,  -1, 8'hA6, 8'hA1, 8'h00, 8'h00);

        #12;
        chk("reset_outputs", {bus.Busy_o, bus.Done_o, bus.RamReadEnable_o, bus.RamAddress_o,
                              bus.StreamData_o, bus.StreamValid_o}, 32'd0);
        @(negedge Clock);
        Reset = 1'b0;

        for (int i = 0; i < 7; i++) run_vec(vecs[i]);

        // Reset in the middle of a long burst after five words have been taken.
        @(negedge Clock);
        bus.Start_i = 1'b1; bus.BaseAddress_i = 4'd0; bus.Length_i = 5'd16; bus.StreamReady_i = 1'b1;
        @(negedge Clock);
        bus.Start_i = 1'b0; bus.Length_i = '0;
        xfers = 0; cnt = 0;
        while (xfers < 5 && cnt < 100) begin
            if (bus.StreamValid_o) xfers++;
            if (xfers < 5) @(negedge Clock);
            cnt++;
        end
        chk("reached_5_transfers", xfers, 5);
        @(posedge Clock);
        #2 Reset = 1'b1;
        #1 chk("midburst_reset_outputs", {bus.Busy_o, bus.Done_o, bus.RamReadEnable_o,
               bus.RamAddress_o, bus.StreamData_o, bus.StreamValid_o}, 32'd0);
        @(negedge Clock);
        @(negedge Clock);
        Reset = 1'b0;
        cnt = 0;
        for (int k = 0; k < 5; k++) begin
            if (bus.Done_o || bus.Busy_o || bus.RamReadEnable_o || bus.StreamValid_o) cnt++;
            @(negedge Clock);
        end
        chk("quiet_after_reset", cnt, 0);
        run_vec(post);

        chk("no_overflow", n_ovf, 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
